// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: one 128-bit state, LANES S-box stages per cycle.
// Define AES_SUBBYTES_SBOX_REG_EN to register S-box outputs before write-back (+1 cycle latency).

module aes_sbox_stage (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [7:0] AFFINE_C = 8'h63;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, built from AND/XOR only.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (t & {8{y[i]}});
            t = {t[6:0], 1'b0} ^ (8'h1b & {8{t[7]}});
        end
        return p;
    endfunction

    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    always_comb begin
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    end

    always_comb begin
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                   inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ AFFINE_C[i];
        end
    end
endmodule

module aes_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NCYC = 16 / LANES;
    localparam int W    = 8 * LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    buf_q, buf_d;
    logic [W-1:0]    lane_in, lane_out;
    logic            accept;
    logic            step;
    logic            wr_en;
    logic [CW-1:0]   wr_idx;
    logic [W-1:0]    wr_data;
    logic            last_wr;

    assign accept  = (state_q == ST_IDLE) && in_valid && !clr;
    assign lane_in = buf_q[int'(cnt_q) * W +: W];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_stage u_sbox (
            .a (lane_in[8*g +: 8]),
            .s (lane_out[8*g +: 8])
        );
    end

`ifdef AES_SUBBYTES_SBOX_REG_EN
    logic [W-1:0]  pipe_q;
    logic [CW-1:0] pipe_idx_q;
    logic          pipe_vld_q;
    logic          issue_done_q;

    // Reads of slice cnt and write-back of slice cnt-1 never overlap.
    assign step    = (state_q == ST_BUSY) && !issue_done_q;
    assign wr_en   = (state_q == ST_BUSY) && pipe_vld_q;
    assign wr_idx  = pipe_idx_q;
    assign wr_data = pipe_q;
    assign last_wr = wr_en && (pipe_idx_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q       <= '0;
            pipe_idx_q   <= '0;
            pipe_vld_q   <= 1'b0;
            issue_done_q <= 1'b0;
        end else if (clr) begin
            pipe_q       <= '0;
            pipe_idx_q   <= '0;
            pipe_vld_q   <= 1'b0;
            issue_done_q <= 1'b0;
        end else begin
            pipe_vld_q <= step;
            if (step) begin
                pipe_q     <= lane_out;
                pipe_idx_q <= cnt_q;
            end
            if (accept)
                issue_done_q <= 1'b0;
            else if (step && (cnt_q == CNT_LAST))
                issue_done_q <= 1'b1;
        end
    end
`else
    assign step    = (state_q == ST_BUSY);
    assign wr_en   = step;
    assign wr_idx  = cnt_q;
    assign wr_data = lane_out;
    assign last_wr = wr_en && (cnt_q == CNT_LAST);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_BUSY;
            ST_BUSY: if (last_wr)   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
        if (clr)
            state_d = ST_IDLE;
    end

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clr) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (accept) begin
            cnt_d = '0;
            buf_d = in_data;
        end else begin
            if (step)
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (wr_en)
                buf_d[int'(wr_idx) * W +: W] = wr_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: the state buffer is reset because its contents must read as zero after any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign out_data  = (state_q == ST_DONE) ? buf_q : '0;
endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq: vector table, corner sequences and random blocks
// checked against a log/antilog-table S-box model.
`timescale 1ns/1ps

module tb_aes_subbytes_seq;
    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;
`ifdef AES_SUBBYTES_SBOX_REG_EN
    localparam int LAT = NCYC + 1;
`else
    localparam int LAT = NCYC;
`endif

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    aes_subbytes_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference S-box from exp/log tables over generator 0x03, then the affine map as rotations.
    logic [7:0] exp_t [256];
    int         log_t [256];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv;
        inv = (b == 8'h00) ? 8'h00 : exp_t[(255 - log_t[b]) % 255];
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] seq_block(input int k);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(16 * k + i);
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Caller is at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
    task automatic start_and_wait(input logic [127:0] din, output int lat);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rand128();
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int           lat;
        int           ov_seen;
        int           nin, nout, cyc, last;
        bit           acc;
        logic [127:0] held;
        logic [127:0] din;

        begin : build_tables
            logic [7:0] x;
            x = 8'h01;
            for (int i = 0; i < 255; i++) begin
                exp_t[i] = x;
                log_t[x] = i;
                x = x ^ xt(x);
            end
            exp_t[255] = 8'h01;
            log_t[0]   = 0;
        end

        vecs[0] = '{128'h0, {16{8'h63}}};
        vecs[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[2] = '{{16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{{16{8'h53}}, {16{8'hed}}};
        vecs[4] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy",      busy,      0);
        check("reset_out_data",  out_data,  0);

        // Release reset and present a state in the same cycle: first rising edge must capture.
        rst_n = 1'b1;
        for (int v = 0; v < 5; v++) begin
            start_and_wait(vecs[v].din, lat);
            check($sformatf("vec%0d_latency", v), 128'(lat), 128'(LAT));
            check($sformatf("vec%0d_data", v), out_data, vecs[v].dout);
            check($sformatf("vec%0d_busy", v), busy, 1);
            release_out();
            check($sformatf("vec%0d_idle", v), in_ready, 1);
        end

        // Stall in DONE for 10 cycles while in_valid pulses with new data.
        din = rand128();
        start_and_wait(din, lat);
        held = out_data;
        check("hold_data", held, sub_ref(din));
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = rand128();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_stable_%0d", c), out_data, held);
            check($sformatf("hold_valid_%0d", c), out_valid, 1);
            check($sformatf("hold_in_ready_%0d", c), in_ready, 0);
        end
        in_valid = 1'b0;
        release_out();
        check("hold_release_idle", in_ready, 1);
        check("hold_release_out_data", out_data, 0);

        // Asynchronous reset in the middle of BUSY, then a fresh state.
        in_valid = 1'b1;
        in_data  = rand128();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat ((NCYC > 2) ? 2 : NCYC - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy",      busy,      0);
        check("midrst_out_data",  out_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(vecs[1].din, lat);
        check("midrst_next_latency", 128'(lat), 128'(LAT));
        check("midrst_next_data", out_data, vecs[1].dout);
        release_out();

        // clr during BUSY: back to IDLE next cycle and out_valid never rises.
        in_valid = 1'b1;
        in_data  = rand128();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat ((NCYC > 1) ? 1 : 0) begin
            @(posedge clk);
            @(negedge clk);
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy_in_ready", in_ready, 1);
        check("clr_busy_busy", busy, 0);
        ov_seen = 0;
        for (int c = 0; c < 2 * LAT + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid || busy) ov_seen++;
        end
        check("clr_busy_no_valid", 128'(ov_seen), 0);

        // clr together with in_valid in IDLE must not capture.
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = rand128();
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_idle_no_capture", busy, 0);
        ov_seen = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("clr_idle_no_valid", 128'(ov_seen), 0);

        // Random states against the reference model, with random stalls before release.
        for (int r = 0; r < 20; r++) begin
            din = rand128();
            start_and_wait(din, lat);
            check($sformatf("rand%0d_latency", r), 128'(lat), 128'(LAT));
            check($sformatf("rand%0d_data", r), out_data, sub_ref(din));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("rand%0d_stalled_data", r), out_data, sub_ref(din));
            release_out();
        end

        // Back-to-back streaming of bytes 0x00..0xFF over 16 blocks.
        out_ready = 1'b1;
        nin = 0; nout = 0; cyc = 0; last = 0;
        while (nout < 16 && cyc < 2000) begin
            in_valid = (nin < 16);
            in_data  = seq_block(nin);
            if (out_valid) begin
                check($sformatf("b2b_data_%0d", nout), out_data, sub_ref(seq_block(nout)));
                if (nout > 0)
                    check($sformatf("b2b_period_%0d", nout), 128'(cyc - last), 128'(LAT + 2));
                last = cyc;
                nout++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            cyc++;
            if (acc) nin++;
            @(negedge clk);
        end
        check("b2b_blocks", 128'(nout), 16);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_subbytes_seq.md
AES_SUBBYTES_SEQ -- requirements
Module: aes_subbytes_seq

Interface
REQ-001 Parameter: LANES, default 4, S-box instances used per cycle; legal values 1, 2, 4, 8, 16; NCYC = 16/LANES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous abort; returns block to IDLE.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block can accept a state.
REQ-007 in_data  input  128  AES state; byte i = in_data[8i+7:8i].
REQ-008 out_valid  output  1  out_data holds a completed SubBytes result.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  128  substituted state, same byte ordering as in_data.
REQ-011 busy  output  1  high in BUSY and DONE.

Function
REQ-012 Each output byte i SHALL equal the AES forward S-box of input byte i, e.g. 0x00->0x63, 0x01->0x7C, 0x53->0xED, 0xFF->0x16.
REQ-013 Substitution SHALL use LANES instances of the team's 8-bit gate-level AES S-box stage; lookup tables are not permitted.
REQ-014 FSM states: IDLE, BUSY, DONE; one 128-bit state buffer; counter cnt of width clog2(NCYC), minimum 1 bit.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, capture in_data into buffer, set cnt=0, go to BUSY.
REQ-016 BUSY: in_ready=0; each cycle replace buffer bytes cnt*LANES..cnt*LANES+LANES-1 with their S-box values, then increment cnt.
REQ-017 BUSY: after the cycle with cnt==NCYC-1 has written, go to DONE; cnt wraps to 0.
REQ-018 DONE: out_valid=1, out_data=buffer, in_ready=0; on out_ready go to IDLE.
REQ-019 Latency: out_valid SHALL rise exactly NCYC cycles after the accepting edge (without macro, REQ-027).
REQ-020 out_data and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 in_valid outside IDLE SHALL be ignored, with no capture and no state change.
REQ-022 out_ready outside DONE SHALL be ignored.
REQ-023 clr SHALL override all other inputs: next state IDLE, cnt=0, out_valid=0, and any in-flight state discarded; clr with in_valid in IDLE SHALL NOT capture.
REQ-024 out_data outside DONE SHALL be 0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, cnt=0, buffer=0, in_ready=1, out_valid=0, busy=0, out_data=0, including mid-operation.
REQ-026 First capture SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro AES_SUBBYTES_SBOX_REG_EN: when defined, S-box outputs SHALL be registered before buffer write-back, adding one cycle, so out_valid rises NCYC+1 cycles after acceptance; the pipeline register resets to 0 and is cleared by clr.
REQ-028 When AES_SUBBYTES_SBOX_REG_EN is undefined, write-back SHALL be combinational from the buffer, with latency NCYC.

Verification
REQ-029 LANES=4, in_data=0 accepted -> out_valid exactly 4 cycles later (5 with macro), out_data=128'h6363...63.
REQ-030 in_data=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=128'hd42711aee0bf98f1b8b45de51e415230, for LANES=1, 4 and 16.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_data stable; in_valid pulses ignored; in_ready=0 throughout.
REQ-032 rst_n pulled low at BUSY cnt=2 -> outputs at reset values immediately; a following state is processed correctly.
REQ-033 clr asserted at BUSY cnt=1 -> IDLE next cycle, out_valid never rises; clr with in_valid in IDLE -> no capture.
REQ-034 Back-to-back: out_ready=1 and in_valid=1 always -> one block per NCYC+2 cycles, outputs match REQ-012 for bytes 0x00..0xFF across 16 blocks.
